// File: rtl/rstgen_seq.sv
// Multi-domain reset sequencer: holds all domains in reset, then releases them in index order.
// Optional macro RSTGEN_SEQ_SWRST_EN lets sw_rst_req_i restart the sequence like rst_i.
module rstgen_seq #(
  parameter int N_DOMAINS   = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 test_mode_i,
  input  logic                 sw_rst_req_i,
  output logic [N_DOMAINS-1:0] rst_no,
  output logic                 init_no,
  output logic                 done_o
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DOMAINS - 1);

  localparam logic [1:0] S_HOLD = 2'd0;
  localparam logic [1:0] S_GAP  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_IDLE = 2'd3;

  logic [1:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [N_DOMAINS-1:0] rst_q;
  logic [N_DOMAINS-1:0] rel_mask;
  logic                 init_q;
  logic                 done_q;
  logic                 restart;

`ifdef RSTGEN_SEQ_SWRST_EN
  assign restart = rst_i | sw_rst_req_i;
`else
  logic unused_sw_rst_req;
  assign unused_sw_rst_req = sw_rst_req_i;
  assign restart = rst_i;
`endif

  // One-hot of the domain addressed by idx; avoids out-of-range bit selects when N_DOMAINS==1.
  assign rel_mask = N_DOMAINS'(1) << idx;

  always_ff @(posedge clk_i) begin
    if (restart) begin
      state  <= S_HOLD;
      cnt    <= '0;
      idx    <= '0;
      rst_q  <= '0;
      init_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            rst_q[0] <= 1'b1;
            cnt      <= '0;
            idx      <= IDX_W'(1);
            state    <= (N_DOMAINS == 1) ? S_DONE : S_GAP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            rst_q <= rst_q | rel_mask;
            cnt   <= '0;
            // idx saturates on the last domain instead of wrapping.
            if (idx == IDX_LAST) begin
              state <= S_DONE;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          init_q <= 1'b1;
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: begin
          done_q <= 1'b0;
        end
      endcase
    end
  end

  // Test mode bypasses the sequencer so scan can drive resets directly from rst_i.
  assign rst_no  = test_mode_i ? {N_DOMAINS{~rst_i}} : rst_q;
  assign init_no = test_mode_i | init_q;
  assign done_o  = ~test_mode_i & done_q;

endmodule

// File: tb/tb_rstgen_seq.sv
// Self-checking bench for rstgen_seq: default build (4/4/8) and a minimal 1/1/1 instance.
// Expected outputs come from an edge-count model of the release schedule.
module tb_rstgen_seq;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       tm = 1'b0;
  logic       sw = 1'b0;
  logic [3:0] rst_no;
  logic       init_no, done_o;
  logic [0:0] rst_no1;
  logic       init_no1, done_o1;

  int  e = 0;
  int  n_checks = 0;
  int  n_fail = 0;
  logic [5:0] exp4, exp1;

  always #5 clk = ~clk;

  rstgen_seq dut (
    .clk_i(clk), .rst_i(rst_i), .test_mode_i(tm), .sw_rst_req_i(sw),
    .rst_no(rst_no), .init_no(init_no), .done_o(done_o)
  );

  rstgen_seq #(.N_DOMAINS(1), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dut1 (
    .clk_i(clk), .rst_i(rst_i), .test_mode_i(tm), .sw_rst_req_i(sw),
    .rst_no(rst_no1), .init_no(init_no1), .done_o(done_o1)
  );

  function automatic bit restart_now();
`ifdef RSTGEN_SEQ_SWRST_EN
    return rst_i | sw;
`else
    return rst_i;
`endif
  endfunction

  // e = number of consecutive edges with no restart since the last restart edge.
  always @(posedge clk) begin
    if (restart_now()) e = 0;
    else if (e < 100000) e = e + 1;
  end

  // Packed as {rst_no[k] at bit 2+k, init_no at bit 1, done_o at bit 0}.
  function automatic logic [5:0] model(int n, int h, int g);
    logic [5:0] v = '0;
    if (tm) begin
      for (int k = 0; k < n; k++) v[2+k] = ~rst_i;
      v[1] = 1'b1;
      return v;
    end
    for (int k = 0; k < n; k++) if (e >= h + k*g) v[2+k] = 1'b1;
    if (e >= h + (n-1)*g + 1) v[1] = 1'b1;
    if (e == h + (n-1)*g + 1) v[0] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({rst_no, init_no, done_o} !== 6'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_dut4 got=%b exp=%b", {rst_no, init_no, done_o}, 6'b0);
      end
      n_checks++;
      if ({rst_no1, init_no1, done_o1} !== 3'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_dut1 got=%b exp=%b", {rst_no1, init_no1, done_o1}, 3'b0);
      end
    end
    rst_i = 1'b0;
  endtask

  task automatic test_sequence();
    for (int i = 1; i <= 35; i++) begin
      @(negedge clk);
      exp4 = model(4, 4, 8);
      exp1 = model(1, 1, 1);
      n_checks++;
      if ({rst_no, init_no, done_o} !== exp4) begin
        n_fail++;
        $display("[TB] FAIL seq_dut4 edge=%0d got=%b exp=%b", i, {rst_no, init_no, done_o}, exp4);
      end
      n_checks++;
      if ({rst_no1, init_no1, done_o1} !== exp1[2:0]) begin
        n_fail++;
        $display("[TB] FAIL seq_dut1 edge=%0d got=%b exp=%b", i, {rst_no1, init_no1, done_o1}, exp1[2:0]);
      end
      if (i == 4 || i == 12 || i == 20 || i == 28 || i == 29) begin
        n_checks++;
        if (rst_no !== 4'((1 << ((i + 4) / 8)) - 1) && i != 29) begin
          n_fail++;
          $display("[TB] FAIL seq_release edge=%0d got=%b", i, rst_no);
        end else if (i == 29 && {rst_no, init_no, done_o} !== 6'b111111) begin
          n_fail++;
          $display("[TB] FAIL seq_done edge=29 got=%b exp=111111", {rst_no, init_no, done_o});
        end
      end
      if (i == 2) begin
        n_checks++;
        if ({init_no1, done_o1} !== 2'b11) begin
          n_fail++;
          $display("[TB] FAIL seq_min_done edge=2 got=%b exp=11", {init_no1, done_o1});
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int dones;
    dones = 0;
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      exp4 = model(4, 4, 8);
      n_checks++;
      if ({rst_no, init_no, done_o} !== exp4) begin
        n_fail++;
        $display("[TB] FAIL mid_dut4 edge=%0d got=%b exp=%b", i, {rst_no, init_no, done_o}, exp4);
      end
    end
    n_checks++;
    if (rst_no !== 4'b0011) begin
      n_fail++;
      $display("[TB] FAIL mid_pre edge=14 got=%b exp=0011", rst_no);
    end
    rst_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({rst_no, init_no, done_o} !== 6'b0) begin
      n_fail++;
      $display("[TB] FAIL mid_abort got=%b exp=000000", {rst_no, init_no, done_o});
    end
    rst_i = 1'b0;
    for (int j = 1; j <= 35; j++) begin
      @(negedge clk);
      exp4 = model(4, 4, 8);
      if (done_o === 1'b1) dones++;
      n_checks++;
      if ({rst_no, init_no, done_o} !== exp4) begin
        n_fail++;
        $display("[TB] FAIL mid_restart edge=%0d got=%b exp=%b", j, {rst_no, init_no, done_o}, exp4);
      end
      if (j == 3 || j == 4) begin
        n_checks++;
        if (rst_no !== ((j == 4) ? 4'b0001 : 4'b0000)) begin
          n_fail++;
          $display("[TB] FAIL mid_first_release edge=%0d got=%b", j, rst_no);
        end
      end
    end
    n_checks++;
    if (dones != 1) begin
      n_fail++;
      $display("[TB] FAIL mid_done_count got=%0d exp=1", dones);
    end
  endtask

  task automatic test_test_mode();
    tm = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rst_i = 1'($urandom_range(0, 1));
      #1;
      n_checks++;
      if ({rst_no, init_no, done_o} !== {{4{~rst_i}}, 2'b10}) begin
        n_fail++;
        $display("[TB] FAIL tmode_dut4 rst=%b got=%b exp=%b", rst_i, {rst_no, init_no, done_o}, {{4{~rst_i}}, 2'b10});
      end
      exp1 = model(1, 1, 1);
      n_checks++;
      if ({rst_no1, init_no1, done_o1} !== exp1[2:0]) begin
        n_fail++;
        $display("[TB] FAIL tmode_dut1 got=%b exp=%b", {rst_no1, init_no1, done_o1}, exp1[2:0]);
      end
    end
    @(negedge clk);
    tm = 1'b0;
    rst_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      exp4 = model(4, 4, 8);
      n_checks++;
      if ({rst_no, init_no, done_o} !== exp4) begin
        n_fail++;
        $display("[TB] FAIL tmode_exit step=%0d got=%b exp=%b", i, {rst_no, init_no, done_o}, exp4);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_swrst();
    n_checks++;
    if ({rst_no, init_no, done_o} !== 6'b111110) begin
      n_fail++;
      $display("[TB] FAIL sw_precond got=%b exp=111110", {rst_no, init_no, done_o});
    end
    sw = 1'b1;
    @(negedge clk);
    @(negedge clk);
    sw = 1'b0;
`ifdef RSTGEN_SEQ_SWRST_EN
    exp4 = 6'b000000;
`else
    exp4 = 6'b111110;
`endif
    n_checks++;
    if ({rst_no, init_no, done_o} !== exp4) begin
      n_fail++;
      $display("[TB] FAIL sw_request got=%b exp=%b", {rst_no, init_no, done_o}, exp4);
    end
    for (int i = 1; i <= 35; i++) begin
      @(negedge clk);
      exp4 = model(4, 4, 8);
      n_checks++;
      if ({rst_no, init_no, done_o} !== exp4) begin
        n_fail++;
        $display("[TB] FAIL sw_after edge=%0d got=%b exp=%b", i, {rst_no, init_no, done_o}, exp4);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      exp4 = model(4, 4, 8);
      exp1 = model(1, 1, 1);
      n_checks++;
      if ({rst_no, init_no, done_o} !== exp4) begin
        n_fail++;
        $display("[TB] FAIL rand_dut4 step=%0d got=%b exp=%b", i, {rst_no, init_no, done_o}, exp4);
      end
      n_checks++;
      if ({rst_no1, init_no1, done_o1} !== exp1[2:0]) begin
        n_fail++;
        $display("[TB] FAIL rand_dut1 step=%0d got=%b exp=%b", i, {rst_no1, init_no1, done_o1}, exp1[2:0]);
      end
      rst_i = ($urandom_range(0, 39) == 0);
      tm    = ($urandom_range(0, 7) == 0);
      sw    = ($urandom_range(0, 29) == 0);
    end
    rst_i = 1'b0;
    tm = 1'b0;
    sw = 1'b0;
  endtask

  initial begin
    $display("[TB] rstgen_seq bench start");
    test_reset();
    test_sequence();
    test_mid_reset();
    test_test_mode();
    test_swrst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
